// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared duty-placement encodings and phase-length helpers for
//               the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam bit c_ODD_LOW_LONG  = 1'b0;
    localparam bit c_ODD_HIGH_LONG = 1'b1;
    localparam int c_FN_W          = 32;

    // For an odd ratio the extra cycle goes to the high or the low phase.
    function automatic logic [c_FN_W-1:0] phase_hi(input logic [c_FN_W-1:0] ratio,
                                                   input bit odd_high_long);
        return (ratio >> 1) + ((odd_high_long && ratio[0]) ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [c_FN_W-1:0] phase_lo(input logic [c_FN_W-1:0] ratio,
                                                   input bit odd_high_long);
        return (ratio >> 1) + ((!odd_high_long && ratio[0]) ? 32'd1 : 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Runtime-programmable integer clock divider with shadowed
//               ratio/enable, per-period tick and reference pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W         = 8,
    parameter bit ODD_HIGH_LONG = c_ODD_HIGH_LONG
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_active
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_TWO = DIV_W'(2);

    logic             r_en;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_cnt;
    logic             r_div_q;
    logic             r_tick_q;

    logic [DIV_W-1:0] w_hi;
    logic [DIV_W-1:0] w_lo;
    logic             w_sel;
    logic             w_new_sel;
    logic             w_boundary;
    logic             w_hi_end;

    assign w_hi = DIV_W'(phase_hi(32'(r_ratio), ODD_HIGH_LONG));
    assign w_lo = DIV_W'(phase_lo(32'(r_ratio), ODD_HIGH_LONG));

    assign w_sel     = r_en && (r_ratio >= c_TWO);
    assign w_new_sel = i_clk_en && (i_div_ratio >= c_TWO);

    // In pass-through every edge is a boundary; when dividing, only the end of the low phase.
    assign w_boundary = !w_sel || (!r_div_q && (r_cnt == w_lo));
    assign w_hi_end   = r_div_q && (r_cnt == w_hi);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en     <= 1'b0;
            r_ratio  <= '0;
            r_cnt    <= c_ONE;
            r_div_q  <= 1'b0;
            r_tick_q <= 1'b0;
        end else if (w_boundary) begin
            r_en     <= i_clk_en;
            r_ratio  <= i_div_ratio;
            r_div_q  <= w_new_sel;
            r_cnt    <= c_ONE;
            r_tick_q <= i_clk_en;
        end else begin
            r_tick_q <= 1'b0;
            if (w_hi_end) begin
                r_div_q <= 1'b0;
                r_cnt   <= c_ONE;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign o_div_clk = w_sel ? r_div_q : i_ref_clk;
    assign o_tick    = r_tick_q;
    assign o_active  = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Directed vector bench for clk_div_prog, both odd-duty modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;
    import clk_div_pkg::*;

    logic       i_ref_clk = 1'b0;
    logic       i_rst_n;
    logic       i_clk_en;
    logic [7:0] i_div_ratio;
    logic       div_hl, tick_hl, act_hl;
    logic       div_ll, tick_ll, act_ll;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic [7:0] ratio;
        logic       exp_hl;
        logic       exp_ll;
        logic       exp_tick;
        logic       exp_act;
    } vec_t;

    vec_t vecs[$];

    always #5 i_ref_clk = ~i_ref_clk;

    clk_div_prog #(.DIV_W(8), .ODD_HIGH_LONG(c_ODD_HIGH_LONG)) u_dut_hl (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_en   (i_clk_en),
        .i_div_ratio(i_div_ratio),
        .o_div_clk  (div_hl),
        .o_tick     (tick_hl),
        .o_active   (act_hl)
    );

    clk_div_prog #(.DIV_W(8), .ODD_HIGH_LONG(c_ODD_LOW_LONG)) u_dut_ll (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_en   (i_clk_en),
        .i_div_ratio(i_div_ratio),
        .o_div_clk  (div_ll),
        .o_tick     (tick_ll),
        .o_active   (act_ll)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic exp_div,
                              input logic exp_tick, input logic exp_act);
        check({name, " div_hl"}, div_hl, exp_div);
        check({name, " div_ll"}, div_ll, exp_div);
        check({name, " tick"}, tick_hl, exp_tick);
        check({name, " tick_ll"}, tick_ll, exp_tick);
        check({name, " active"}, act_hl, exp_act);
        check({name, " active_ll"}, act_ll, exp_act);
    endtask

    task automatic step();
        @(posedge i_ref_clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [7:0] r, input logic hl,
                       input logic ll, input logic tk, input logic ac);
        vec_t v;
        v.en = en; v.ratio = r; v.exp_hl = hl; v.exp_ll = ll; v.exp_tick = tk; v.exp_act = ac;
        vecs.push_back(v);
    endtask

    initial begin
        int hi_len;
        // N=4 from reset: 2 high / 2 low, tick every 4
        add(1, 4, 1, 1, 1, 1); add(1, 4, 1, 1, 0, 1); add(1, 4, 0, 0, 0, 1); add(1, 4, 0, 0, 0, 1);
        add(1, 4, 1, 1, 1, 1); add(1, 4, 1, 1, 0, 1); add(1, 4, 0, 0, 0, 1); add(1, 4, 0, 0, 0, 1);
        // N=5: 3/2 in high-long mode, 2/3 in low-long mode
        add(1, 5, 1, 1, 1, 1); add(1, 5, 1, 1, 0, 1); add(1, 5, 1, 0, 0, 1); add(1, 5, 0, 0, 0, 1);
        add(1, 5, 0, 0, 0, 1);
        // N=6 latched, then 3 requested mid-high: 6-cycle period completes first
        add(1, 6, 1, 1, 1, 1); add(1, 3, 1, 1, 0, 1); add(1, 3, 1, 1, 0, 1); add(1, 3, 0, 0, 0, 1);
        add(1, 3, 0, 0, 0, 1); add(1, 3, 0, 0, 0, 1);
        add(1, 3, 1, 1, 1, 1); add(1, 3, 1, 0, 0, 1); add(1, 3, 0, 0, 0, 1);
        // N=8, enable dropped mid-high: period finishes, then pass-through
        add(1, 8, 1, 1, 1, 1); add(1, 8, 1, 1, 0, 1); add(0, 8, 1, 1, 0, 1); add(0, 8, 1, 1, 0, 1);
        add(0, 8, 0, 0, 0, 1); add(0, 8, 0, 0, 0, 1); add(0, 8, 0, 0, 0, 1); add(0, 8, 0, 0, 0, 1);
        add(0, 8, 1, 1, 0, 0); add(0, 8, 1, 1, 0, 0);

        i_rst_n     = 1'b0;
        i_clk_en    = 1'b1;
        i_div_ratio = 8'd4;
        #2;
        check_both("reset low phase", 1'b0, 1'b0, 1'b0);
        step();
        check_both("reset high phase", 1'b1, 1'b0, 1'b0);
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;

        foreach (vecs[i]) begin
            i_clk_en    = vecs[i].en;
            i_div_ratio = vecs[i].ratio;
            step();
            check($sformatf("row%0d div_hl", i + 1), div_hl, vecs[i].exp_hl);
            check($sformatf("row%0d div_ll", i + 1), div_ll, vecs[i].exp_ll);
            check($sformatf("row%0d tick", i + 1), tick_hl, vecs[i].exp_tick);
            check($sformatf("row%0d tick_ll", i + 1), tick_ll, vecs[i].exp_tick);
            check($sformatf("row%0d active", i + 1), act_hl, vecs[i].exp_act);
            check($sformatf("row%0d active_ll", i + 1), act_ll, vecs[i].exp_act);
        end

        // Disabled pass-through follows the reference low level too
        @(negedge i_ref_clk);
        #1;
        check_both("disabled low", 1'b0, 1'b0, 1'b0);

        // Ratios 1 and 0 with enable: pass-through, tick every cycle
        for (int r = 1; r >= 0; r--) begin
            i_clk_en    = 1'b1;
            i_div_ratio = 8'(r);
            for (int k = 0; k < 3; k++) begin
                step();
                check_both($sformatf("N=%0d high", r), 1'b1, 1'b1, 1'b0);
                @(negedge i_ref_clk);
                #1;
                check_both($sformatf("N=%0d low", r), 1'b0, 1'b1, 1'b0);
            end
        end

        // N=10, async reset while the divided clock is high and the reference low
        i_div_ratio = 8'd10;
        step();
        check_both("N=10 enter", 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_both("N=10 mid-high", 1'b1, 1'b0, 1'b1);
        #5;
        i_rst_n = 1'b0;
        #1;
        check_both("async reset", 1'b0, 1'b0, 1'b0);
        step();
        check_both("in reset", 1'b1, 1'b0, 1'b0);
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;
        hi_len = int'(phase_hi(32'd10, c_ODD_HIGH_LONG));
        for (int k = 1; k <= 6; k++) begin
            step();
            check_both($sformatf("post-reset edge%0d", k), (k <= hi_len) ? 1'b1 : 1'b0,
                       (k == 1) ? 1'b1 : 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
